// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings,
// reset/bubble defaults and PC arithmetic.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  // Sequential PC, 32-bit modulo so the top word wraps to address 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request, tracks the PC
// and owns the IF/ID pipeline register.
//
// state    | meaning
// ST_FETCH | request for pc outstanding, word goes straight to IF/ID
// ST_HOLD  | word parked in r_buf while decode stalls, no request
// ST_DROP  | redirected mid-request, waiting to discard word for r_drop_addr
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_next,
  output logic        id_valid
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_buf, w_buf_nxt;
  logic [31:0]  r_drop_addr, w_drop_nxt;
  logic [31:0]  r_id_instr, r_id_pc_next;
  logic         r_id_valid;
  logic         w_eff_stall;
  logic         w_take;
  logic [31:0]  w_take_data;

  // A flush empties IF/ID anyway, so a stall must not park the flushed word.
  assign w_eff_stall = stall & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_drop_nxt  = r_drop_addr;
    w_take      = 1'b0;
    w_take_data = r_buf;
    case (r_state)
      ST_FETCH: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
          if (!imem_ready) begin
            w_drop_nxt  = r_pc;
            w_state_nxt = ST_DROP;
          end
        end else if (imem_ready) begin
          if (w_eff_stall) begin
            w_buf_nxt   = imem_data;
            w_state_nxt = ST_HOLD;
          end else begin
            w_take      = 1'b1;
            w_take_data = imem_data;
            w_pc_nxt    = pc_inc(r_pc);
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_FETCH;
        end else if (!w_eff_stall) begin
          w_take      = 1'b1;
          w_take_data = r_buf;
          w_pc_nxt    = pc_inc(r_pc);
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end
        if (imem_ready) begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_buf       <= '0;
      r_drop_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_buf       <= w_buf_nxt;
      r_drop_addr <= w_drop_nxt;
    end
  end

  // IF/ID: an unstalled cycle with nothing to load becomes a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_id_instr   <= NOP_INSTR;
      r_id_pc_next <= RESET_PC;
      r_id_valid   <= 1'b0;
    end else if (flush) begin
      r_id_instr <= NOP_INSTR;
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      if (w_take) begin
        r_id_instr   <= w_take_data;
        r_id_pc_next <= pc_inc(r_pc);
        r_id_valid   <= 1'b1;
      end else begin
        r_id_instr <= NOP_INSTR;
        r_id_valid <= 1'b0;
      end
    end
  end

  assign imem_req   = reset & (r_state != ST_HOLD);
  assign imem_addr  = (r_state == ST_DROP) ? r_drop_addr : r_pc;
  assign id_instr   = r_id_instr;
  assign id_pc_next = r_id_pc_next;
  assign id_valid   = r_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a memory model answers the expected address,
// accepted words are queued and matched against IF/ID when they arrive there.
module tb_fetch_stage;

  localparam logic [31:0] A   = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int ACT_HOLD = 0;
  localparam int ACT_LOAD = 1;
  localparam int ACT_BUB  = 2;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid, imem_ready;
  logic [31:0] redirect_pc, imem_data;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc_next;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcn;
  } exp_t;
  exp_t sb[$];

  logic [31:0] e_instr, e_pcn;
  logic        e_valid;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .id_instr      (id_instr),
    .id_pc_next    (id_pc_next),
    .id_valid      (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check request, clock, check IF/ID against the scoreboard.
  task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                      input logic rdy, input logic keep, input logic ereq,
                      input logic [31:0] eaddr, input int act, input string tag);
    exp_t e;
    stall          = st;
    flush          = fl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    imem_data      = rdy ? mem(eaddr) : 32'hDEAD_BEEF;
    if (rdy && keep) sb.push_back('{mem(eaddr), eaddr + 32'd4});
    #1;
    chk({tag, ".req"}, 32'(imem_req), 32'(ereq));
    if (ereq) chk({tag, ".addr"}, imem_addr, eaddr);
    @(posedge clk);
    #1;
    case (act)
      ACT_LOAD: begin
        chk({tag, ".sb"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e       = sb.pop_front();
          e_instr = e.instr;
          e_pcn   = e.pcn;
          e_valid = 1'b1;
        end
      end
      ACT_BUB: begin
        e_instr = NOP;
        e_valid = 1'b0;
      end
      default: ;
    endcase
    chk({tag, ".instr"}, id_instr, e_instr);
    chk({tag, ".pcn"}, id_pc_next, e_pcn);
    chk({tag, ".valid"}, 32'(id_valid), 32'(e_valid));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_ready = 1'b1; imem_data = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("rst.req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("rst.instr", id_instr, NOP);
    chk("rst.pcn", id_pc_next, A);
    chk("rst.valid", 32'(id_valid), 32'd0);
    reset = 1'b1;
    e_instr = NOP; e_pcn = A; e_valid = 1'b0;

    // streaming, one instruction per cycle
    step(0, 0, 0, '0, 1, 1, 1, A,           ACT_LOAD, "s1");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h4,   ACT_LOAD, "s2");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h8,   ACT_LOAD, "s3");
    // 3-cycle stall, word parked in the buffer
    step(1, 0, 0, '0, 1, 1, 1, A + 32'hC,   ACT_HOLD, "st1");
    step(1, 0, 0, '0, 0, 0, 0, '0,          ACT_HOLD, "st2");
    step(1, 0, 0, '0, 0, 0, 0, '0,          ACT_HOLD, "st3");
    step(0, 0, 0, '0, 0, 0, 0, '0,          ACT_LOAD, "st4");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h10,  ACT_LOAD, "st5");
    // memory not ready for two cycles
    step(0, 0, 0, '0, 0, 0, 1, A + 32'h14,  ACT_BUB,  "nr1");
    step(0, 0, 0, '0, 0, 0, 1, A + 32'h14,  ACT_BUB,  "nr2");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h14,  ACT_LOAD, "nr3");
    // redirect while request outstanding
    step(0, 0, 1, A + 32'h100, 0, 0, 1, A + 32'h18, ACT_BUB, "dr1");
    step(0, 0, 0, '0, 0, 0, 1, A + 32'h18,  ACT_BUB,  "dr2");
    step(0, 0, 0, '0, 1, 0, 1, A + 32'h18,  ACT_BUB,  "dr3");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h100, ACT_LOAD, "dr4");
    // redirect with ready word
    step(0, 0, 1, A + 32'h200, 1, 0, 1, A + 32'h104, ACT_BUB, "rr1");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h200, ACT_LOAD, "rr2");
    // second redirect while dropping
    step(0, 0, 1, A + 32'h300, 0, 0, 1, A + 32'h204, ACT_BUB, "dd1");
    step(0, 0, 1, A + 32'h400, 0, 0, 1, A + 32'h204, ACT_BUB, "dd2");
    step(0, 0, 0, '0, 1, 0, 1, A + 32'h204, ACT_BUB,  "dd3");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h400, ACT_LOAD, "dd4");
    // stall without data, then redirect out of HOLD
    step(1, 0, 0, '0, 0, 0, 1, A + 32'h404, ACT_HOLD, "hr1");
    step(1, 0, 0, '0, 1, 0, 1, A + 32'h404, ACT_HOLD, "hr2");
    step(1, 0, 1, A + 32'h500, 0, 0, 0, '0, ACT_HOLD, "hr3");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h500, ACT_LOAD, "hr4");
    // flush overrides stall
    step(1, 1, 1, A + 32'h600, 1, 0, 1, A + 32'h504, ACT_BUB, "fl1");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h600, ACT_LOAD, "fl2");
    // PC wrap at top of address space
    step(0, 0, 1, 32'hFFFF_FFFC, 1, 0, 1, A + 32'h604, ACT_BUB, "wr1");
    step(0, 0, 0, '0, 1, 1, 1, 32'hFFFF_FFFC, ACT_LOAD, "wr2");
    step(0, 0, 0, '0, 1, 1, 1, 32'h0000_0000, ACT_LOAD, "wr3");
    // reset while a word sits in HOLD
    step(1, 0, 0, '0, 1, 0, 1, 32'h0000_0004, ACT_HOLD, "rh1");
    reset = 1'b0;
    imem_data = mem(32'h4);
    #1;
    chk("rh.req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("rh.instr", id_instr, NOP);
    chk("rh.pcn", id_pc_next, A);
    chk("rh.valid", 32'(id_valid), 32'd0);
    reset = 1'b1;
    e_instr = NOP; e_pcn = A; e_valid = 1'b0;
    sb.delete();
    step(0, 0, 0, '0, 1, 1, 1, A,           ACT_LOAD, "rh2");
    step(0, 0, 0, '0, 1, 1, 1, A + 32'h4,   ACT_LOAD, "rh3");

    chk("sb.left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, address fetched first after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word used as a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 stall  input  1  hazard stall from decode; IF/ID register must hold.
REQ-006 flush  input  1  squash IF/ID contents (branch/jump taken).
REQ-007 redirect_valid  input  1  load redirect_pc as next fetch address.
REQ-008 redirect_pc  input  32  redirect target, word aligned.
REQ-009 imem_req  output  1  instruction memory request, level.
REQ-010 imem_addr  output  32  request address, stable while imem_req=1 and imem_ready=0.
REQ-011 imem_ready  input  1  imem_data valid this cycle; completes the request.
REQ-012 imem_data  input  32  fetched instruction.
REQ-013 id_instr  output  32  IF/ID instruction register.
REQ-014 id_pc_next  output  32  IF/ID PC+4 of id_instr.
REQ-015 id_valid  output  1  IF/ID holds a real instruction.

Function
REQ-016 SHALL implement FSM states FETCH (request issued), HOLD (word buffered, decode stalled), DROP (returning word to be discarded).
REQ-017 FETCH: imem_req=1, imem_addr=pc; HOLD: imem_req=0; DROP: imem_req=1, imem_addr=drop_addr.
REQ-018 FETCH, imem_ready=1, redirect_valid=0, stall=0: id_instr<=imem_data, id_pc_next<=pc+4, id_valid<=1, pc<=pc+4, stay FETCH (zero-bubble throughput, 1 instr/cycle).
REQ-019 FETCH, imem_ready=1, stall=1, redirect_valid=0: IF/ID holds, buf<=imem_data, go HOLD; pc unchanged.
REQ-020 HOLD, stall=0, redirect_valid=0: IF/ID loaded from buf and pc+4, pc<=pc+4, go FETCH.
REQ-021 FETCH, imem_ready=0, stall=0: IF/ID loaded with NOP_INSTR, id_valid<=0 (bubble); id_pc_next unchanged.
REQ-022 FETCH, imem_ready=1, redirect_valid=1: data discarded, pc<=redirect_pc, stay FETCH.
REQ-023 FETCH, imem_ready=0, redirect_valid=1: drop_addr<=pc, pc<=redirect_pc, go DROP.
REQ-024 DROP, imem_ready=1: data discarded, go FETCH; new redirect same cycle updates pc.
REQ-025 DROP, imem_ready=0, redirect_valid=1: pc<=redirect_pc, stay DROP; drop_addr unchanged.
REQ-026 HOLD, redirect_valid=1: buf discarded, pc<=redirect_pc, go FETCH.
REQ-027 flush=1: id_instr<=NOP_INSTR, id_valid<=0 next edge, overriding stall and any load; FSM/pc still follow REQ-018..026, except a word that would enter IF/ID goes to HOLD-less discard only if redirect_valid=1, otherwise is buffered per REQ-019 semantics with stall treated as 0.
REQ-028 stall=1 without flush: id_instr, id_pc_next, id_valid SHALL hold unchanged in every state.
REQ-029 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-030 redirect_valid SHALL take priority over stall for pc/FSM updates.

Reset
REQ-031 reset=0 at an edge: pc<=RESET_PC, state<=FETCH, id_instr<=NOP_INSTR, id_pc_next<=RESET_PC, id_valid<=0, buf<=0, drop_addr<=0.
REQ-032 While reset=0, imem_req SHALL be 0; a memory response during reset is ignored.
REQ-033 Reset mid-DROP or mid-HOLD SHALL abandon the pending word; first request after release is RESET_PC.

Structure
REQ-034 FSM state encodings, NOP_INSTR and RESET_PC defaults SHALL live in the shared defines header.
REQ-035 Single module, no sub-modules; IF/ID register, buffer and FSM are local.

Verification
REQ-036 Reset release, imem_ready=1 always, no stall: imem_addr 0x00400000,0x00400004,...; id_pc_next 0x00400004 one cycle after first request.
REQ-037 stall=1 for 3 cycles with ready=1: IF/ID frozen, imem_req=0 in HOLD, next instruction appears the cycle after stall drops, none lost or duplicated.
REQ-038 imem_ready=0 for 2 cycles: two bubbles (id_valid=0, id_instr=0), imem_addr stable throughout.
REQ-039 redirect_valid=1 to 0x00400100 while ready=0: DROP entered, imem_addr stays old until ready, old word discarded, next request 0x00400100.
REQ-040 flush=1 and stall=1 same cycle: id_valid=0, id_instr=NOP next cycle.
REQ-041 reset=0 asserted while in HOLD: after release id_valid=0, first imem_addr=RESET_PC.
